// File: rtl/mux_arbiter_pkg.sv
// mux_arbiter shared types: arbiter states, owner encodings, reset owner.
package mux_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic OWNER_A  = 1'b0;
    localparam logic OWNER_B  = 1'b1;
    // B counts as last owner out of reset so A wins the first contention
    localparam logic LAST_RST = OWNER_B;

endpackage

// File: rtl/mux_always.sv
// Shared 2:1 data mux; sel=0 passes in_A, sel=1 passes in_B.
module mux_always #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = in_A;
        if (sel) out = in_B;
    end

endmodule

// File: rtl/mux_arbiter.sv
// Two-requester round-robin burst arbiter driving the shared 2:1 mux.
// MUX_ARBITER_OUT_REG_EN adds a 1-entry output register after the mux.
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel,
    output logic [1:0]       grant
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    state_t          state;
    state_t          state_nx;
    logic            last;
    logic            last_nx;
    logic [CW-1:0]   burst_cnt;
    logic [CW-1:0]   cnt_nx;
    logic            sel_q;
    logic [WIDTH-1:0] mux_out;

    logic own;
    logic owner;
    logic own_valid;
    logic other_valid;
    logic own_ready;
    logic xfer;

    mux_always #(
        .WIDTH (WIDTH)
    ) u_mux (
        .in_A (a_data),
        .in_B (b_data),
        .sel  (sel),
        .out  (mux_out)
    );

    assign own         = (state != IDLE) && !rst;
    assign owner       = (state == OWN_B);
    assign own_valid   = owner ? b_valid : a_valid;
    assign other_valid = owner ? a_valid : b_valid;
    assign xfer        = own && own_valid && own_ready;

`ifdef MUX_ARBITER_OUT_REG_EN
    logic             reg_full;
    logic [WIDTH-1:0] reg_data;

    assign own_ready = !reg_full || out_ready;
    assign out_valid = reg_full && !rst;
    assign out_data  = out_valid ? reg_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_full <= 1'b0;
            reg_data <= '0;
        end else if (xfer) begin
            reg_full <= 1'b1;
            reg_data <= mux_out;
        end else if (out_ready) begin
            reg_full <= 1'b0;
        end
    end
`else
    assign own_ready = out_ready;
    assign out_valid = own && own_valid;
    assign out_data  = own ? mux_out : '0;
`endif

    always_comb begin
        sel     = sel_q;
        grant   = 2'b00;
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (rst) begin
            sel = 1'b0;
        end else begin
            unique case (state)
                OWN_A: begin
                    sel     = OWNER_A;
                    grant   = 2'b01;
                    a_ready = own_ready;
                end
                OWN_B: begin
                    sel     = OWNER_B;
                    grant   = 2'b10;
                    b_ready = own_ready;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        last_nx  = last;
        cnt_nx   = burst_cnt;
        unique case (state)
            IDLE: begin
                if (a_valid && (!b_valid || last == OWNER_B))
                    state_nx = OWN_A;
                else if (b_valid)
                    state_nx = OWN_B;
            end
            OWN_A, OWN_B: begin
                if (xfer) cnt_nx = burst_cnt + 1'b1;
                // release on the final beat of a burst or when the owner idles
                if ((xfer && burst_cnt == LAST_BEAT) || !own_valid) begin
                    last_nx = owner;
                    cnt_nx  = '0;
                    if (other_valid)
                        state_nx = owner ? OWN_A : OWN_B;
                    else
                        state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= LAST_RST;
            burst_cnt <= '0;
            sel_q     <= 1'b0;
        end else begin
            state     <= state_nx;
            last      <= last_nx;
            burst_cnt <= cnt_nx;
            sel_q     <= sel;
        end
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed table-driven bench for mux_arbiter (MAX_BURST=4 and MAX_BURST=2).
module tb_mux_arbiter;

    typedef struct {
        logic       rst;
        logic       av;
        logic [7:0] ad;
        logic       bv;
        logic [7:0] bd;
        logic       ordy;
        logic       ov;
        logic [7:0] od;
        logic       ar;
        logic       br;
        logic       sel;
        logic [1:0] gnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_valid = 1'b0;
    logic [7:0] a_data = '0;
    logic       b_valid = 1'b0;
    logic [7:0] b_data = '0;
    logic       out_ready = 1'b0;

    logic       ar4, br4, ov4, sel4;
    logic [7:0] od4;
    logic [1:0] g4;
    logic       ar2, br2, ov2, sel2;
    logic [7:0] od2;
    logic [1:0] g2;

    int n_chk  = 0;
    int n_fail = 0;

    vec_t tbl[$];

    always #5 clk = ~clk;

    mux_arbiter #(.WIDTH(8), .MAX_BURST(4)) u4 (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_ready(ar4),
        .b_valid(b_valid), .b_data(b_data), .b_ready(br4),
        .out_valid(ov4), .out_data(od4), .out_ready(out_ready),
        .sel(sel4), .grant(g4)
    );

    mux_arbiter #(.WIDTH(8), .MAX_BURST(2)) u2 (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_ready(ar2),
        .b_valid(b_valid), .b_data(b_data), .b_ready(br2),
        .out_valid(ov2), .out_data(od2), .out_ready(out_ready),
        .sel(sel2), .grant(g2)
    );

    function automatic vec_t v(
        input logic rs, input logic av, input logic [7:0] ad,
        input logic bv, input logic [7:0] bd, input logic ordy,
        input logic ov, input logic [7:0] od, input logic ar,
        input logic br, input logic sl, input logic [1:0] g);
        vec_t r;
        r.rst = rs; r.av = av; r.ad = ad; r.bv = bv; r.bd = bd;
        r.ordy = ordy; r.ov = ov; r.od = od; r.ar = ar; r.br = br;
        r.sel = sl; r.gnt = g;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        a_data = '0; b_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_tbl(input string tag, input int which);
        logic       ov, ar, br, sl;
        logic [7:0] od;
        logic [1:0] g;
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            rst = tbl[i].rst; out_ready = tbl[i].ordy;
            a_valid = tbl[i].av; a_data = tbl[i].ad;
            b_valid = tbl[i].bv; b_data = tbl[i].bd;
            @(negedge clk);
            if (which == 2) begin
                ov = ov2; od = od2; ar = ar2; br = br2; sl = sel2; g = g2;
            end else begin
                ov = ov4; od = od4; ar = ar4; br = br4; sl = sel4; g = g4;
            end
            chk($sformatf("%s[%0d].out_valid", tag, i), 32'(ov), 32'(tbl[i].ov));
            chk($sformatf("%s[%0d].out_data", tag, i), 32'(od), 32'(tbl[i].od));
            chk($sformatf("%s[%0d].a_ready", tag, i), 32'(ar), 32'(tbl[i].ar));
            chk($sformatf("%s[%0d].b_ready", tag, i), 32'(br), 32'(tbl[i].br));
            chk($sformatf("%s[%0d].sel", tag, i), 32'(sl), 32'(tbl[i].sel));
            chk($sformatf("%s[%0d].grant", tag, i), 32'(g), 32'(tbl[i].gnt));
        end
    endtask

    logic [7:0] exp_ord [12];
    logic [7:0] got[$];
    int ai;
    int bi;

    initial begin
        exp_ord = '{8'hA1, 8'hA2, 8'hB1, 8'hB2, 8'hA3, 8'hA4,
                    8'hB3, 8'hB4, 8'hA5, 8'hA6, 8'hB5, 8'hB6};

`ifndef MUX_ARBITER_OUT_REG_EN
        // contention, MAX_BURST=2: A,A,B,B,A,A with no gaps
        tbl = {};
        tbl.push_back(v(0,0,8'h00,0,8'h00,1, 0,8'h00,0,0,0,2'b00));
        tbl.push_back(v(0,1,8'hA1,1,8'hB1,1, 0,8'h00,0,0,0,2'b00));
        tbl.push_back(v(0,1,8'hA1,1,8'hB1,1, 1,8'hA1,1,0,0,2'b01));
        tbl.push_back(v(0,1,8'hA2,1,8'hB1,1, 1,8'hA2,1,0,0,2'b01));
        tbl.push_back(v(0,1,8'hA3,1,8'hB1,1, 1,8'hB1,0,1,1,2'b10));
        tbl.push_back(v(0,1,8'hA3,1,8'hB2,1, 1,8'hB2,0,1,1,2'b10));
        tbl.push_back(v(0,1,8'hA3,1,8'hB3,1, 1,8'hA3,1,0,0,2'b01));
        tbl.push_back(v(0,1,8'hA4,1,8'hB3,1, 1,8'hA4,1,0,0,2'b01));
        tbl.push_back(v(0,0,8'h00,0,8'h00,1, 0,8'h00,0,1,1,2'b10));
        tbl.push_back(v(0,0,8'h00,0,8'h00,1, 0,8'h00,0,0,1,2'b00));
        do_reset();
        run_tbl("contend", 2);

        // A only, MAX_BURST=4: 4 beats, 1-cycle idle gap, 2 beats
        tbl = {};
        tbl.push_back(v(0,1,8'hA1,0,8'h00,1, 0,8'h00,0,0,0,2'b00));
        tbl.push_back(v(0,1,8'hA1,0,8'h00,1, 1,8'hA1,1,0,0,2'b01));
        tbl.push_back(v(0,1,8'hA2,0,8'h00,1, 1,8'hA2,1,0,0,2'b01));
        tbl.push_back(v(0,1,8'hA3,0,8'h00,1, 1,8'hA3,1,0,0,2'b01));
        tbl.push_back(v(0,1,8'hA4,0,8'h00,1, 1,8'hA4,1,0,0,2'b01));
        tbl.push_back(v(0,1,8'hA5,0,8'h00,1, 0,8'h00,0,0,0,2'b00));
        tbl.push_back(v(0,1,8'hA5,0,8'h00,1, 1,8'hA5,1,0,0,2'b01));
        tbl.push_back(v(0,1,8'hA6,0,8'h00,1, 1,8'hA6,1,0,0,2'b01));
        tbl.push_back(v(0,0,8'h00,0,8'h00,1, 0,8'h00,1,0,0,2'b01));
        tbl.push_back(v(0,0,8'h00,0,8'h00,1, 0,8'h00,0,0,0,2'b00));
        do_reset();
        run_tbl("a_only", 4);

        // backpressure: 5 stalled cycles must not advance the burst count
        tbl = {};
        tbl.push_back(v(0,1,8'hA1,0,8'h00,1, 0,8'h00,0,0,0,2'b00));
        tbl.push_back(v(0,1,8'hA1,0,8'h00,1, 1,8'hA1,1,0,0,2'b01));
        for (int k = 0; k < 5; k++)
            tbl.push_back(v(0,1,8'hA2,0,8'h00,0, 1,8'hA2,0,0,0,2'b01));
        tbl.push_back(v(0,1,8'hA2,0,8'h00,1, 1,8'hA2,1,0,0,2'b01));
        tbl.push_back(v(0,1,8'hA3,0,8'h00,1, 1,8'hA3,1,0,0,2'b01));
        tbl.push_back(v(0,1,8'hA4,0,8'h00,1, 1,8'hA4,1,0,0,2'b01));
        tbl.push_back(v(0,1,8'hA5,0,8'h00,1, 0,8'h00,0,0,0,2'b00));
        do_reset();
        run_tbl("stall", 4);

        // owner drops valid: B takes over with a fresh 4-beat burst
        tbl = {};
        tbl.push_back(v(0,1,8'hA1,0,8'h00,1, 0,8'h00,0,0,0,2'b00));
        tbl.push_back(v(0,1,8'hA1,0,8'h00,1, 1,8'hA1,1,0,0,2'b01));
        tbl.push_back(v(0,0,8'h00,1,8'hB1,1, 0,8'h00,1,0,0,2'b01));
        tbl.push_back(v(0,0,8'h00,1,8'hB1,1, 1,8'hB1,0,1,1,2'b10));
        tbl.push_back(v(0,0,8'h00,1,8'hB2,1, 1,8'hB2,0,1,1,2'b10));
        tbl.push_back(v(0,0,8'h00,1,8'hB3,1, 1,8'hB3,0,1,1,2'b10));
        tbl.push_back(v(0,0,8'h00,1,8'hB4,1, 1,8'hB4,0,1,1,2'b10));
        tbl.push_back(v(0,0,8'h00,1,8'hB5,1, 0,8'h00,0,0,1,2'b00));
        tbl.push_back(v(0,0,8'h00,1,8'hB5,1, 1,8'hB5,0,1,1,2'b10));
        do_reset();
        run_tbl("drop", 4);

        // reset after 2 of 4 B beats; A must win afterwards
        tbl = {};
        tbl.push_back(v(0,1,8'hA1,0,8'h00,1, 0,8'h00,0,0,0,2'b00));
        tbl.push_back(v(0,1,8'hA1,0,8'h00,1, 1,8'hA1,1,0,0,2'b01));
        tbl.push_back(v(0,0,8'h00,1,8'hB1,1, 0,8'h00,1,0,0,2'b01));
        tbl.push_back(v(0,0,8'h00,1,8'hB1,1, 1,8'hB1,0,1,1,2'b10));
        tbl.push_back(v(0,0,8'h00,1,8'hB2,1, 1,8'hB2,0,1,1,2'b10));
        tbl.push_back(v(1,1,8'hA1,1,8'hB3,1, 0,8'h00,0,0,0,2'b00));
        tbl.push_back(v(0,1,8'hA1,1,8'hB3,1, 0,8'h00,0,0,0,2'b00));
        tbl.push_back(v(0,1,8'hA1,1,8'hB3,1, 1,8'hA1,1,0,0,2'b01));
        do_reset();
        run_tbl("midrst", 4);
`else
        // registered output: same contention order, one cycle later
        tbl = {};
        tbl.push_back(v(0,0,8'h00,0,8'h00,1, 0,8'h00,0,0,0,2'b00));
        tbl.push_back(v(0,1,8'hA1,1,8'hB1,1, 0,8'h00,0,0,0,2'b00));
        tbl.push_back(v(0,1,8'hA1,1,8'hB1,1, 0,8'h00,1,0,0,2'b01));
        tbl.push_back(v(0,1,8'hA2,1,8'hB1,1, 1,8'hA1,1,0,0,2'b01));
        tbl.push_back(v(0,1,8'hA3,1,8'hB1,1, 1,8'hA2,0,1,1,2'b10));
        tbl.push_back(v(0,1,8'hA3,1,8'hB2,1, 1,8'hB1,0,1,1,2'b10));
        tbl.push_back(v(0,1,8'hA3,1,8'hB3,1, 1,8'hB2,1,0,0,2'b01));
        tbl.push_back(v(0,1,8'hA4,1,8'hB3,1, 1,8'hA3,1,0,0,2'b01));
        tbl.push_back(v(0,0,8'h00,0,8'h00,1, 1,8'hA4,0,1,1,2'b10));
        tbl.push_back(v(0,0,8'h00,0,8'h00,1, 0,8'h00,0,0,1,2'b00));
        do_reset();
        run_tbl("contend_reg", 2);
`endif

        // handshaking sources with out_ready toggling every cycle
        do_reset();
        ai = 0;
        bi = 0;
        got = {};
        for (int c = 0; c < 200 && got.size() < 12; c++) begin
            @(posedge clk);
            #1;
            out_ready = (c % 2 == 0);
            a_valid   = (ai < 6);
            a_data    = a_valid ? 8'(8'hA1 + ai) : 8'h00;
            b_valid   = (bi < 6);
            b_data    = b_valid ? 8'(8'hB1 + bi) : 8'h00;
            @(negedge clk);
            if (a_valid && ar2) ai++;
            if (b_valid && br2) bi++;
            if (ov2 && out_ready) got.push_back(od2);
        end
        chk("order.count", 32'(got.size()), 32'd12);
        for (int k = 0; k < 12 && k < got.size(); k++)
            chk($sformatf("order[%0d]", k), 32'(got[k]), 32'(exp_ord[k]));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Two-requester round-robin arbiter that shares one 2:1 data mux between requesters A and B and presents a single valid/ready output stream. It sits in front of the shared mux and owns its `sel` line. Each requester can hold the grant for a bounded burst of transfers before ownership rotates. Upstream sources and the downstream sink connect through standard valid/ready handshakes.

## Interface
- `WIDTH`, default 1: data width of each requester and of the output.
- `MAX_BURST`, default 4: maximum consecutive transfers per grant. Legal range is ≥1.
- `clk`  input  1: the only clock. All logic is rising-edge.
- `rst`  input  1: synchronous, active-high reset.
- `a_valid`  input  1: requester A has data.
- `a_data`  input  WIDTH: requester A data.
- `a_ready`  output  1: A's beat is accepted this cycle.
- `b_valid`  input  1: requester B has data.
- `b_data`  input  WIDTH: requester B data.
- `b_ready`  output  1: B's beat is accepted this cycle.
- `out_valid`  output  1: output beat valid.
- `out_data`  output  WIDTH: output beat.
- `out_ready`  input  1: sink accepts the output beat.
- `sel`  output  1: mux select. 0 selects A, 1 selects B.
- `grant`  output  2: one-hot current owner. Bit 0 is A, bit 1 is B. Value 00 means idle.

## Operation
- FSM states:
  - IDLE.
  - OWN_A.
  - OWN_B.
- Registers:
  - `state`.
  - `last`: last owner, 0 = A, 1 = B.
  - `burst_cnt`: width clog2(MAX_BURST+1).
- Reset values:
  - state = IDLE, last = 1, so A wins the first contention. burst_cnt = 0.
  - Outputs: `out_valid`=0, `out_data`=0, `a_ready`=0, `b_ready`=0, `sel`=0, `grant`=00.
- IDLE:
  - No requests: stay in IDLE.
  - Only A valid: go to OWN_A. Only B valid: go to OWN_B.
  - Both valid: grant the requester ≠ `last`.
  - All outputs are deasserted. `sel` holds its previous value.
- OWN_x:
  - `sel` = x, `grant` = one-hot x.
  - `out_valid` = x_valid and `out_data` = x_data, taken through the mux.
  - x_ready = out_ready. The other ready is 0.
- Transfer is defined as out_valid & out_ready. Each transfer increments burst_cnt.
- Release conditions:
  - (a) A transfer occurs with burst_cnt+1 == MAX_BURST.
  - (b) x_valid is low: no transfer, the requester has gone idle.
- On release:
  - last ← x and burst_cnt ← 0.
  - If the other requester's valid is high in the same cycle, go directly to OWN_other. Otherwise go to IDLE.
- Requester rule: valid, once high, holds with stable data until ready. The arbiter relies on this: it never revokes a grant while the owner's valid is high, except via (a), and (a) occurs only on a completed transfer.
- Reset mid-burst: state, counter and outputs return to reset values on the next edge. No beat is emitted from the reset cycle onward.

## Timing
- Arbitration latency is 1 cycle: a request seen in IDLE is granted from the next cycle.
- In the combinational path (macro off), output latency is 0 cycles from owner valid to `out_valid`.
- Handoff OWN_A→OWN_B has no bubble when B is waiting at release.
- Sustained contention with MAX_BURST=N gives N beats of A, then N beats of B, with 100% throughput.
- MAX_BURST=1 alternates beat by beat.

## Configuration
- `MUX_ARBITER_OUT_REG_EN` defined:
  - A 1-entry output register sits after the mux. `out_valid`/`out_data` are registered, so latency is +1 cycle.
  - Owner ready = !reg_full | out_ready, which gives full throughput.
  - Transfer and burst counting happen on the upstream handshake (x_valid & x_ready).
  - The register resets to empty with data 0.
- Not defined: the output is the combinational mux path, as in Operation.

## Structure
- Package `mux_arbiter_pkg` holds:
  - The state enum (IDLE, OWN_A, OWN_B).
  - Owner encodings (OWNER_A=0, OWNER_B=1).
  - The reset value of `last`.
- Data selection instantiates the existing `mux_always` (WIDTH passed through) with in_A=a_data, in_B=b_data, sel=`sel`.
- No other sub-modules.

## Test plan
- Reset then A only: a_valid=1 for 6 beats, out_ready=1, MAX_BURST=4.
  - `grant` goes 01 one cycle after a_valid.
  - Beats 1–4 pass, then a 1-cycle IDLE gap, then beats 5–6 pass.
  - b_ready stays 0 throughout.
- Simultaneous a_valid=b_valid=1 from reset, MAX_BURST=2.
  - Output order is A,A,B,B,A,A with no gaps after the first grant.
  - `sel` toggles accordingly.
- Backpressure: out_ready=0 for 5 cycles while owning A.
  - burst_cnt stays unchanged and the grant is held.
  - a_ready=0 and out_data is stable.
- Owner drops valid: A owns, a_valid falls while b_valid=1.
  - Next cycle is OWN_B.
  - A's counter state does not carry over.
- Reset asserted mid-burst (after 2 of 4 beats).
  - Next cycle: all outputs are 0 and `grant`=00.
  - After release, A wins the next contention.
- With `MUX_ARBITER_OUT_REG_EN`, repeat the contention scenario.
  - Same beat order, shifted 1 cycle.
  - No beat lost or duplicated when out_ready toggles every cycle.
